traffic_phase_ctrl: RTL and testbench

Phase sequencer for the intersection. It drives the main-street and side-street lamps through fixed green/yellow/red phases. It services the latched pedestrian request held by the walk register by inserting an all-red WALK phase, and it clears that register with a one-cycle `wr_reset` pulse. Optionally, a side-street car sensor extends side green. It sits between the walk register (input `wr`, output `wr_reset`) and the lamp drivers.

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/phase_timer.sv | 39 +++
 rtl/traffic_phase_ctrl.sv | 166 ++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase encoding and lamp constants for the intersection
// phase sequencer (traffic_phase_ctrl and its phase_timer).
package traffic_pkg;

  // Phases the sequencer walks through, in service order
  typedef enum logic [2:0] {
    MAIN_GO,
    MAIN_YEL,
    WALK,
    SIDE_GO,
    SIDE_YEL
  } phase_e;

  // One-hot lamp encodings, bit order {R,Y,G}
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Lamp pattern {main, side, walk} shown while in a given phase.
  // Unused encodings fall back to the safe MAIN_GO pattern so the lamps are
  // never dark or two-coloured.
  function automatic logic [6:0] phase_lamps(input phase_e p);
    case (p)
      MAIN_GO:  return {LAMP_G, LAMP_R, 1'b0};
      MAIN_YEL: return {LAMP_Y, LAMP_R, 1'b0};
      WALK:     return {LAMP_R, LAMP_R, 1'b1};
      SIDE_GO:  return {LAMP_R, LAMP_G, 1'b0};
      SIDE_YEL: return {LAMP_R, LAMP_Y, 1'b0};
      default:  return {LAMP_G, LAMP_R, 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: down-counter measuring the length of the current phase.
// Loaded with (length - 1) when a phase begins; expire is high on the last
// cycle of the phase, i.e. while the count sits at zero.
module phase_timer #(
  parameter int                CNT_W     = 8,
  parameter logic [CNT_W-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Reload on phase entry, otherwise count down and park at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register; reset leaves the first phase's full length loaded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: intersection phase sequencer.
// Cycles main/side lamps through green and yellow, inserts an all-red WALK
// phase when the walk register holds a request at the end of main yellow,
// and clears that register with a one-cycle wr_reset pulse on WALK entry.
// Optional feature macro: TRAFFIC_SENSOR_EXTEND_EN -- when defined, a car
// seen on the sensor during the first SIDE_GO cycle stretches side green by
// T_EXT cycles. When undefined the sensor port is kept but ignored.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int T_BASE = 8,
  parameter int T_YEL  = 3,
  parameter int T_EXT  = 4,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr,
  input  logic       sensor,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       wr_reset
);

  // Refuse to elaborate with durations the timer cannot represent
  if (T_BASE < 1 || T_YEL < 1 || T_EXT < 1 || CNT_W < 1 ||
      (longint'(T_BASE) + longint'(T_EXT)) > (longint'(1) << CNT_W)) begin : g_bad_params
    $error("traffic_phase_ctrl: durations must be >= 1 and T_BASE+T_EXT <= 2**CNT_W");
  end

  // Timer load values are phase length minus one
  localparam logic [CNT_W-1:0] LEN_BASE = CNT_W'(T_BASE - 1);
  localparam logic [CNT_W-1:0] LEN_YEL  = CNT_W'(T_YEL - 1);
  localparam logic [CNT_W-1:0] LEN_WALK = CNT_W'(T_EXT - 1);

  phase_e           state_q;
  phase_e           state_d;
  logic             expire;
  logic             ext_load;
  logic             timer_load;
  logic [CNT_W-1:0] load_val;

  logic [2:0]       main_light_q;
  logic [2:0]       main_light_d;
  logic [2:0]       side_light_q;
  logic [2:0]       side_light_d;
  logic             walk_q;
  logic             walk_d;
  logic             wr_reset_q;
  logic             wr_reset_d;

`ifdef TRAFFIC_SENSOR_EXTEND_EN
  // Entry cycle of SIDE_GO has already used one cycle of the base count,
  // so the reload covers the remaining T_BASE+T_EXT-1 cycles.
  localparam logic [CNT_W-1:0] LEN_SIDE_EXT = CNT_W'(T_BASE + T_EXT - 2);

  logic entry_q;
  logic entry_d;

  // Flag the first cycle of every phase so the sensor is sampled exactly once
  always_comb begin
    entry_d = (state_d != state_q);
  end

  // Entry flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
    end
  end

  // Stretch side green when a car is waiting as side green begins
  always_comb begin
    ext_load = (state_q == SIDE_GO) && entry_q && sensor;
  end
`else
  logic unused_sensor;

  assign unused_sensor = sensor;
  assign ext_load      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MAIN_GO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: advance when the phase timer runs out, unless side green
  // is being stretched in that same cycle
  always_comb begin
    state_d = state_q;
    if (expire && !ext_load) begin
      case (state_q)
        MAIN_GO:  state_d = MAIN_YEL;
        MAIN_YEL: state_d = wr ? WALK : SIDE_GO;
        WALK:     state_d = SIDE_GO;
        SIDE_GO:  state_d = SIDE_YEL;
        SIDE_YEL: state_d = MAIN_GO;
        default:  state_d = MAIN_GO;
      endcase
    end
  end

  // Timer reload: length of the phase being entered, or the stretched side green
  always_comb begin
    timer_load = (state_d != state_q) || ext_load;
    case (state_d)
      MAIN_GO,
      SIDE_GO:  load_val = LEN_BASE;
      MAIN_YEL,
      SIDE_YEL: load_val = LEN_YEL;
      WALK:     load_val = LEN_WALK;
      default:  load_val = LEN_BASE;
    endcase
`ifdef TRAFFIC_SENSOR_EXTEND_EN
    if (ext_load) begin
      load_val = LEN_SIDE_EXT;
    end
`endif
  end

  phase_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (LEN_BASE)
  ) u_phase_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (load_val),
    .expire   (expire)
  );

  // Output decode from the next state so lamps switch on the same edge as the state
  always_comb begin
    {main_light_d, side_light_d, walk_d} = phase_lamps(state_d);
    wr_reset_d = (state_d == WALK) && (state_q != WALK);
  end

  // Output registers; reset shows main green with side red
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_light_q <= LAMP_G;
      side_light_q <= LAMP_R;
      walk_q       <= 1'b0;
      wr_reset_q   <= 1'b0;
    end else begin
      main_light_q <= main_light_d;
      side_light_q <= side_light_d;
      walk_q       <= walk_d;
      wr_reset_q   <= wr_reset_d;
    end
  end

  assign main_light = main_light_q;
  assign side_light = side_light_q;
  assign walk       = walk_q;
  assign wr_reset   = wr_reset_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: table-driven bench for the intersection sequencer.
// Each table row is one expected phase (lamps, length, stimulus); rows are
// expanded into per-cycle expectations, queued when stimulus is driven and
// compared against the DUT mid-cycle. A behavioural walk register feeds wr.
module tb_traffic_phase_ctrl;

  localparam int T_BASE = 8;
  localparam int T_YEL  = 3;
  localparam int T_EXT  = 4;
  localparam int CNT_W  = 8;

`ifdef TRAFFIC_SENSOR_EXTEND_EN
  localparam int SIDE_EXT = 12;
`else
  localparam int SIDE_EXT = 8;
`endif

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  typedef struct {
    string      name;
    logic [2:0] exp_main;
    logic [2:0] exp_side;
    logic       exp_walk;
    int         cycles;
    int         press_at;
    logic       sens_first;
    logic       sens_rest;
  } phase_vec_t;

  typedef struct {
    string      name;
    logic [7:0] value;
  } sb_entry_t;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr      = 1'b0;
  logic       sensor  = 1'b0;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic       wr_reset;

  sb_entry_t  sb_q[$];
  phase_vec_t vecs[$];
  int         check_count = 0;
  int         pass_count  = 0;

  traffic_phase_ctrl #(
    .T_BASE (T_BASE),
    .T_YEL  (T_YEL),
    .T_EXT  (T_EXT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr         (wr),
    .sensor     (sensor),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .wr_reset   (wr_reset)
  );

  always #5 clk = ~clk;

  // Output bundle is {main_light, side_light, walk, wr_reset}
  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %b_%b_%b_%b, required %b_%b_%b_%b", name,
               actual[7:5], actual[4:2], actual[1], actual[0],
               expected[7:5], expected[4:2], expected[1], expected[0]);
    end
  endtask

  // One clock cycle: drive inputs at cycle start, check mid-cycle, then let
  // the walk register model update on the edge (clear has priority over press)
  task automatic applyStimulus(input string name, input logic press, input logic sens,
                               input logic [7:0] expected);
    sb_entry_t e;
    sb_entry_t got;
    logic      wr_next;
    sensor  = sens;
    e.name  = name;
    e.value = expected;
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    checkOutput(got.name, {main_light, side_light, walk, wr_reset}, got.value);
    wr_next = wr_reset ? 1'b0 : (press ? 1'b1 : wr);
    @(posedge clk);
    #1;
    wr = wr_next;
  endtask

  task automatic runPhase(input phase_vec_t v);
    for (int i = 0; i < v.cycles; i++) begin
      applyStimulus($sformatf("%s[%0d]", v.name, i), (i == v.press_at),
                    (i == 0) ? v.sens_first : v.sens_rest,
                    {v.exp_main, v.exp_side, v.exp_walk, (v.exp_walk && i == 0)});
    end
  endtask

  function automatic phase_vec_t mk(input string name, input logic [2:0] m, input logic [2:0] s,
                                    input logic w, input int cyc, input int press_at = -1,
                                    input logic sf = 1'b0, input logic sr = 1'b0);
    phase_vec_t v;
    v.name       = name;
    v.exp_main   = m;
    v.exp_side   = s;
    v.exp_walk   = w;
    v.cycles     = cyc;
    v.press_at   = press_at;
    v.sens_first = sf;
    v.sens_rest  = sr;
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Round 1: free run, no requests
    vecs.push_back(mk("r1_main_go",  G, R, 1'b0, T_BASE));
    vecs.push_back(mk("r1_main_yel", Y, R, 1'b0, T_YEL));
    vecs.push_back(mk("r1_side_go",  R, G, 1'b0, T_BASE));
    vecs.push_back(mk("r1_side_yel", R, Y, 1'b0, T_YEL));
    // Round 2: press mid main green; a press on the wr_reset cycle is lost
    vecs.push_back(mk("r2_main_go",  G, R, 1'b0, T_BASE, 3));
    vecs.push_back(mk("r2_main_yel", Y, R, 1'b0, T_YEL));
    vecs.push_back(mk("r2_walk",     R, R, 1'b1, T_EXT, 0));
    vecs.push_back(mk("r2_side_go",  R, G, 1'b0, T_BASE));
    vecs.push_back(mk("r2_side_yel", R, Y, 1'b0, T_YEL));
    // Round 3: no walk (lost press), sensor held through side green
    vecs.push_back(mk("r3_main_go",  G, R, 1'b0, T_BASE));
    vecs.push_back(mk("r3_main_yel", Y, R, 1'b0, T_YEL));
    vecs.push_back(mk("r3_side_go",  R, G, 1'b0, SIDE_EXT, -1, 1'b1, 1'b1));
    vecs.push_back(mk("r3_side_yel", R, Y, 1'b0, T_YEL));
    // Round 4: walk, with a new press landing after the clear pulse
    vecs.push_back(mk("r4_main_go",  G, R, 1'b0, T_BASE, 2));
    vecs.push_back(mk("r4_main_yel", Y, R, 1'b0, T_YEL));
    vecs.push_back(mk("r4_walk",     R, R, 1'b1, T_EXT, 1));
    vecs.push_back(mk("r4_side_go",  R, G, 1'b0, T_BASE));
    vecs.push_back(mk("r4_side_yel", R, Y, 1'b0, T_YEL));
    // Round 5: latched request is serviced without a new press
    vecs.push_back(mk("r5_main_go",  G, R, 1'b0, T_BASE));
    vecs.push_back(mk("r5_main_yel", Y, R, 1'b0, T_YEL));
    vecs.push_back(mk("r5_walk",     R, R, 1'b1, T_EXT));
    vecs.push_back(mk("r5_side_go",  R, G, 1'b0, T_BASE));
    vecs.push_back(mk("r5_side_yel", R, Y, 1'b0, T_YEL));
    // Round 6: sensor only on the entry cycle of side green
    vecs.push_back(mk("r6_main_go",  G, R, 1'b0, T_BASE));
    vecs.push_back(mk("r6_main_yel", Y, R, 1'b0, T_YEL));
    vecs.push_back(mk("r6_side_go",  R, G, 1'b0, SIDE_EXT, -1, 1'b1, 1'b0));
    vecs.push_back(mk("r6_side_yel", R, Y, 1'b0, T_YEL));
    // Round 7: sensor arrives after entry and is ignored
    vecs.push_back(mk("r7_main_go",  G, R, 1'b0, T_BASE));
    vecs.push_back(mk("r7_main_yel", Y, R, 1'b0, T_YEL));
    vecs.push_back(mk("r7_side_go",  R, G, 1'b0, T_BASE, -1, 1'b0, 1'b1));
    vecs.push_back(mk("r7_side_yel", R, Y, 1'b0, T_YEL));

    $display("[TB] reset held for 3 cycles");
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_values", {main_light, side_light, walk, wr_reset}, {G, R, 1'b0, 1'b0});
    reset_n = 1'b1;

    $display("[TB] running %0d phase vectors", vecs.size());
    for (int k = 0; k < vecs.size(); k++) begin
      runPhase(vecs[k]);
    end

    $display("[TB] reset during WALK");
    runPhase(mk("rw_main_go",  G, R, 1'b0, T_BASE, 1));
    runPhase(mk("rw_main_yel", Y, R, 1'b0, T_YEL));
    applyStimulus("rw_walk[0]", 1'b0, 1'b0, {R, R, 1'b1, 1'b1});
    applyStimulus("rw_walk[1]", 1'b0, 1'b0, {R, R, 1'b1, 1'b0});
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_mid_walk", {main_light, side_light, walk, wr_reset}, {G, R, 1'b0, 1'b0});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("reset_hold[%0d]", i), {main_light, side_light, walk, wr_reset},
                  {G, R, 1'b0, 1'b0});
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
    runPhase(mk("ra_main_go",  G, R, 1'b0, T_BASE));
    runPhase(mk("ra_main_yel", Y, R, 1'b0, T_YEL));
    runPhase(mk("ra_side_go",  R, G, 1'b0, T_BASE));
    runPhase(mk("ra_side_yel", R, Y, 1'b0, T_YEL));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
